// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one functional-unit result per cycle into a registered CDB stage.
// Optional performance counters are built when CDB_PERF_CNT_EN is defined.
module cdb_arbiter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int NREQ  = 3,
  parameter int SRC_W = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  input  logic [NREQ*XLEN-1:0]  req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  cdb_stall,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_tag,
  output logic [XLEN-1:0]       cdb_data,
  output logic [SRC_W-1:0]      cdb_src
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_conflict,
  output logic [31:0]           perf_stall
`endif
);

  logic             cdb_valid_q;
  logic [TAG_W-1:0] cdb_tag_q;
  logic [XLEN-1:0]  cdb_data_q;
  logic [SRC_W-1:0] cdb_src_q;
  logic [SRC_W-1:0] rr_ptr_q;
  logic [SRC_W-1:0] rr_ptr_d;

  logic adv;
  logic found;
  logic grant;
  int   win_idx;

  assign adv   = !cdb_valid_q || !cdb_stall;
  assign grant = resetn && adv && !flush && found;

  // Circular priority scan starting at the round-robin pointer.
  always_comb begin
    int idx;
    found   = 1'b0;
    win_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win_idx] = 1'b1;
  end

  assign rr_ptr_d = (win_idx == NREQ - 1) ? '0 : SRC_W'(win_idx + 1);

  // CDB output stage: load on grant, go idle when free with nothing to send, hold under stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else if (flush) begin
      cdb_valid_q <= 1'b0;
    end else if (adv) begin
      cdb_valid_q <= found;
      if (found) begin
        cdb_tag_q  <= req_tag[win_idx*TAG_W +: TAG_W];
        cdb_data_q <= req_data[win_idx*XLEN +: XLEN];
        cdb_src_q  <= SRC_W'(win_idx);
        rr_ptr_q   <= rr_ptr_d;
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

`ifdef CDB_PERF_CNT_EN
  logic [31:0] perf_conflict_q;
  logic [31:0] perf_stall_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_conflict_q <= '0;
      perf_stall_q    <= '0;
    end else if (flush) begin
      perf_conflict_q <= '0;
      perf_stall_q    <= '0;
    end else begin
      if (adv && ($countones(req_valid) > 1)) perf_conflict_q <= sat_inc(perf_conflict_q);
      if (cdb_valid_q && cdb_stall)           perf_stall_q    <= sat_inc(perf_stall_q);
    end
  end

  assign perf_conflict = perf_conflict_q;
  assign perf_stall    = perf_stall_q;
`endif

endmodule
